regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources:
  - Source A: the in-order ALU pipeline.
  - Source B: the long-latency unit (mul/div/load).
- Each source has a valid/ready handshake and a 1-entry pending slot.
- Round-robin arbitration with an age rule for same-register conflicts.
- Drives registered wr_en/wr_addr/wr_data straight into the register file, which captures them on the following negedge.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_wb_arbiter_if.sv | 54 +++++
 rtl/wb_slot.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Latency: none (types and constants only).
// Backpressure: n/a.
//
// Contents: XLEN/AW widths, REG_ZERO, wb_entry_t pending-slot record and
// entry_hit(), a lookup helper that never matches x0.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            v;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // A valid entry matches a nonzero register address.
  function automatic logic entry_hit(input wb_entry_t e, input logic [AW-1:0] ra);
    return e.v && (e.addr == ra) && (ra != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two writeback sources, the arbiter and the register file.
// Latency: wires only.
// Backpressure: a_ready/b_ready from the arbiter throttle each source.
//
// Signals: a_* / b_* valid-ready writeback requests, wr_* registered write port,
// busy. With WB_BYPASS_EN defined: rs1_addr/rs2_addr lookups returning
// byp1_hit/byp1_data and byp2_hit/byp2_data.
// Modports: master = source/decode side, slave = arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_addr;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_addr;
  logic [XLEN-1:0] b_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            busy;

`ifdef WB_BYPASS_EN
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            byp1_hit;
  logic [XLEN-1:0] byp1_data;
  logic            byp2_hit;
  logic [XLEN-1:0] byp2_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rs1_addr, rs2_addr,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, busy,
           byp1_hit, byp1_data, byp2_hit, byp2_data
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, rs1_addr, rs2_addr,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, busy,
           byp1_hit, byp1_data, byp2_hit, byp2_data
  );
`else
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, busy
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, busy
  );
`endif

endinterface

// File: rtl/wb_slot.sv
// One-entry pending writeback slot with load, clear and address compare.
// Latency: loads on the posedge of the accepting handshake.
// Backpressure: none internally; the owner derives ready from entry.v and its grant.
//
// Ports: clk, rst (sync, active-high); acc = handshake completed; clr = slot
// granted this cycle; ld_addr/ld_data = incoming request; cmp_addr/cmp_hit =
// address compare against the held entry; entry = held state; loaded = slot
// actually captured a request this edge (x0 requests are accepted but dropped).
module wb_slot
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            acc,
  input  logic            clr,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [AW-1:0]   cmp_addr,
  output wb_entry_t       entry,
  output logic            loaded,
  output logic            cmp_hit
);

  assign loaded  = acc && (ld_addr != REG_ZERO);
  assign cmp_hit = entry.v && (entry.addr == cmp_addr);

  // A refill wins over the clear, so back-to-back writebacks keep the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= '0;
    end else if (loaded) begin
      entry <= '{v: 1'b1, addr: ld_addr, data: ld_data};
    end else if (clr) begin
      entry.v <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU (A) and long-latency (B) writebacks.
// Latency: accepted at posedge N -> wr_en in cycle N+1; each lost contention round adds one cycle.
// Backpressure: per-source 1-entry slot; ready = slot empty or slot granted this cycle.
//
// Ports: clk, rst (sync, active-high), bus (regfile_wb_arbiter_if.slave):
// a_*/b_* writeback handshakes, registered wr_en/wr_addr/wr_data, busy.
// Optional WB_BYPASS_EN adds rs1/rs2 lookups against the pending slots and the
// write register; without it, decode has to stall on busy.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  wb_entry_t       pa, pb;
  logic            pa_loaded, pb_loaded;
  logic            pa_hit, pb_hit;
  logic            grant_a, grant_b;
  logic            contended, same_addr;
  logic            older_b;   // pb accepted strictly before pa
  logic            tie;       // pa and pb accepted on the same edge
  logic            rr_b;      // B wins the next different-address contention
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [XLEN-1:0] wr_data_q;

  wb_slot u_slot_a (
    .clk      (clk),
    .rst      (rst),
    .acc      (bus.a_valid && bus.a_ready),
    .clr      (grant_a),
    .ld_addr  (bus.a_addr),
    .ld_data  (bus.a_data),
    .cmp_addr (pb.addr),
    .entry    (pa),
    .loaded   (pa_loaded),
    .cmp_hit  (pa_hit)
  );

  wb_slot u_slot_b (
    .clk      (clk),
    .rst      (rst),
    .acc      (bus.b_valid && bus.b_ready),
    .clr      (grant_b),
    .ld_addr  (bus.b_addr),
    .ld_data  (bus.b_data),
    .cmp_addr (pa.addr),
    .entry    (pb),
    .loaded   (pb_loaded),
    .cmp_hit  (pb_hit)
  );

  assign contended = pa.v && pb.v;
  assign same_addr = pa_hit && pb_hit;

  // Same register: the older value is written first so the younger one lands
  // last. On a same-edge tie B goes first, leaving A's (in-order) value final.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (contended) begin
      grant_b = same_addr ? (older_b || tie) : rr_b;
      grant_a = !grant_b;
    end else begin
      grant_a = pa.v;
      grant_b = pb.v;
    end
  end

  assign bus.a_ready = !rst && (!pa.v || grant_a);
  assign bus.b_ready = !rst && (!pb.v || grant_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      older_b   <= 1'b0;
      tie       <= 1'b0;
      rr_b      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // The loser of any contention gets priority next, bounding the wait
      // of a pending slot to one lost round.
      if (contended) begin
        rr_b <= grant_a;
      end

      if (pa_loaded && pb_loaded) begin
        older_b <= 1'b0;
        tie     <= 1'b1;
      end else if (pb_loaded && pa.v && !grant_a) begin
        older_b <= 1'b0;
        tie     <= 1'b0;
      end else if (pa_loaded && pb.v && !grant_b) begin
        older_b <= 1'b1;
        tie     <= 1'b0;
      end

      wr_en_q <= grant_a || grant_b;
      if (grant_a) begin
        wr_addr_q <= pa.addr;
        wr_data_q <= pa.data;
      end else if (grant_b) begin
        wr_addr_q <= pb.addr;
        wr_data_q <= pb.data;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = pa.v || pb.v || wr_en_q;

`ifdef WB_BYPASS_EN
  // Youngest value first: the pending slot that will be written last, then
  // the other slot, then the write register still in flight to the file.
  function automatic logic [XLEN:0] byp_lookup(input logic [AW-1:0] ra);
    wb_entry_t young, old;
    young = (older_b || tie) ? pa : pb;
    old   = (older_b || tie) ? pb : pa;
    if (entry_hit(young, ra)) return {1'b1, young.data};
    if (entry_hit(old, ra))   return {1'b1, old.data};
    if (wr_en_q && (wr_addr_q == ra) && (ra != REG_ZERO)) return {1'b1, wr_data_q};
    return '0;
  endfunction

  always_comb begin
    {bus.byp1_hit, bus.byp1_data} = byp_lookup(bus.rs1_addr);
  end

  always_comb begin
    {bus.byp2_hit, bus.byp2_data} = byp_lookup(bus.rs2_addr);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by a random phase,
// checked every cycle against a transaction-level model of the writeback rules.
// Also exercises the WB_BYPASS_EN lookup ports when that macro is defined.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Outstanding accepted writeback, stamped with the cycle it was handed over.
  typedef struct {
    bit              src_b;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    int              stamp;
  } m_ent_t;

  m_ent_t          oq[$];        // values waiting in the arbiter
  bit              inf_v;        // a value was chosen for the write port last cycle
  m_ent_t          inf;
  bit              rr_m;         // B wins the next different-register contention
  logic [AW-1:0]   last_addr;
  logic [XLEN-1:0] last_data;
  logic [XLEN-1:0] rf [32];      // register file fed by the write port
  logic [XLEN-1:0] exp_rf [32];
  logic [AW-1:0]   wr_log[$];
  logic [XLEN-1:0] x7_log[$];
  int              n_cyc, n_vec, n_bad;
  bit              acc_a, acc_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef WB_BYPASS_EN
  // Latest accepted value wins (same-cycle: A is the later one), then the write port.
  function automatic logic [XLEN:0] m_byp(input logic [AW-1:0] ra);
    bit     found;
    m_ent_t best;
    found = 1'b0;
    best  = '{1'b0, '0, '0, 0};
    if (ra == REG_ZERO) return '0;
    foreach (oq[i]) begin
      if (oq[i].addr == ra &&
          (!found || oq[i].stamp > best.stamp || (oq[i].stamp == best.stamp && !oq[i].src_b))) begin
        best  = oq[i];
        found = 1'b1;
      end
    end
    if (found) return {1'b1, best.data};
    if (inf_v && inf.addr == ra) return {1'b1, inf.data};
    return '0;
  endfunction

  task automatic check_byp();
    logic [XLEN:0] e1, e2;
    e1 = m_byp(bus.rs1_addr);
    e2 = m_byp(bus.rs2_addr);
    check("byp1_hit", 32'(bus.byp1_hit), 32'(e1[XLEN]));
    if (e1[XLEN]) check("byp1_data", bus.byp1_data, e1[XLEN-1:0]);
    check("byp2_hit", 32'(bus.byp2_hit), 32'(e2[XLEN]));
    if (e2[XLEN]) check("byp2_data", bus.byp2_data, e2[XLEN-1:0]);
  endtask
`endif

  // One clock: check the write port and readies at negedge, update the model,
  // then return just after the following posedge.
  task automatic cyc();
    int ia, ib;
    bit ea, eb, win_b;
    @(negedge clk);
    n_cyc++;
    check("wr_en", 32'(bus.wr_en), 32'(inf_v));
    if (inf_v) begin
      last_addr          = inf.addr;
      last_data          = inf.data;
      exp_rf[inf.addr]   = inf.data;
    end
    check("wr_addr", 32'(bus.wr_addr), 32'(last_addr));
    check("wr_data", bus.wr_data, last_data);
    if (bus.wr_en === 1'b1) begin
      if (bus.wr_addr != REG_ZERO) rf[bus.wr_addr] = bus.wr_data;
      wr_log.push_back(bus.wr_addr);
      if (bus.wr_addr == 5'd7) x7_log.push_back(bus.wr_data);
    end
    check("busy", 32'(bus.busy), 32'((oq.size() != 0) || inf_v));

    inf_v = 1'b0;
    acc_a = 1'b0;
    acc_b = 1'b0;
    ia = -1;
    ib = -1;
    foreach (oq[i]) begin
      if (oq[i].src_b) ib = i;
      else             ia = i;
    end

    if (rst) begin
      check("a_ready_rst", 32'(bus.a_ready), 32'(0));
      check("b_ready_rst", 32'(bus.b_ready), 32'(0));
      oq.delete();
      last_addr = '0;
      last_data = '0;
      rr_m      = 1'b0;
    end else begin
      if (ia >= 0 && ib >= 0) begin
        if (oq[ia].addr == oq[ib].addr) win_b = (oq[ib].stamp <= oq[ia].stamp);
        else                            win_b = rr_m;
        rr_m = !win_b;
        ea   = !win_b;
        eb   = win_b;
      end else begin
        ea    = 1'b1;
        eb    = 1'b1;
        win_b = (ib >= 0);
      end
      check("a_ready", 32'(bus.a_ready), 32'(ea));
      check("b_ready", 32'(bus.b_ready), 32'(eb));
      if (ia >= 0 || ib >= 0) begin
        inf_v = 1'b1;
        inf   = oq[win_b ? ib : ia];
        oq.delete(win_b ? ib : ia);
      end
      acc_a = bus.a_valid && ea;
      acc_b = bus.b_valid && eb;
      if (acc_b && bus.b_addr != REG_ZERO) oq.push_back('{1'b1, bus.b_addr, bus.b_data, n_cyc});
      if (acc_a && bus.a_addr != REG_ZERO) oq.push_back('{1'b0, bus.a_addr, bus.a_data, n_cyc});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int na, nb, guard;
    logic [AW-1:0]   seq [6];
    logic [XLEN-1:0] exp7 [4];

    n_vec = 0; n_bad = 0; n_cyc = 0;
    inf_v = 1'b0; rr_m = 1'b0; last_addr = '0; last_data = '0;
    acc_a = 1'b0; acc_b = 1'b0;
    foreach (rf[i]) begin
      rf[i]     = '0;
      exp_rf[i] = '0;
    end
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
`ifdef WB_BYPASS_EN
    bus.rs1_addr = '0; bus.rs2_addr = '0;
`endif

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;
    #1;
    check("rst_wr_en", 32'(bus.wr_en), 32'(0));
    check("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("rst_wr_data", bus.wr_data, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_a_ready", 32'(bus.a_ready), 32'(1));
    check("rst_b_ready", 32'(bus.b_ready), 32'(1));

    // Single write: x5 = DEADBEEF appears on the port one cycle after acceptance
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
    cyc();
    bus.a_valid = 1'b0;
    check("single_wr_en_early", 32'(bus.wr_en), 32'(0));
    cyc();
    check("single_wr_en", 32'(bus.wr_en), 32'(1));
    check("single_wr_addr", 32'(bus.wr_addr), 32'(5));
    check("single_wr_data", bus.wr_data, 32'hDEADBEEF);
    cyc();
    check("single_rf_x5", rf[5], 32'hDEADBEEF);

    // Contention: three back-to-back pairs alternate A,B,A,B,...
    na = 0; nb = 0; guard = 0;
    wr_log.delete();
    while ((na < 3 || nb < 3) && guard < 30) begin
      bus.a_valid = (na < 3); bus.a_addr = 5'd1; bus.a_data = 32'h11 + (32'(na) << 8);
      bus.b_valid = (nb < 3); bus.b_addr = 5'd2; bus.b_data = 32'h22 + (32'(nb) << 8);
      cyc();
      na += int'(acc_a);
      nb += int'(acc_b);
      guard++;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    check("cont_accepts", 32'(na + nb), 32'(6));
    repeat (3) cyc();
    seq = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2};
    check("cont_writes", 32'(wr_log.size()), 32'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < wr_log.size()) check("cont_order", 32'(wr_log[i]), 32'(seq[i]));
    end
    check("cont_rf_x1", rf[1], 32'h211);
    check("cont_rf_x2", rf[2], 32'h222);

    // Same register: B then A on consecutive cycles, then both on one cycle
    x7_log.delete();
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'hB;
    cyc();
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'hA;
    cyc();
    bus.a_valid = 1'b0;
    repeat (3) cyc();
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'hA;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'hB;
    cyc();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    repeat (3) cyc();
    exp7 = '{32'hB, 32'hA, 32'hB, 32'hA};
    check("x7_writes", 32'(x7_log.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < x7_log.size()) check("x7_order", x7_log[i], exp7[i]);
    end
    check("x7_final", rf[7], 32'hA);

    // x0 request is accepted and dropped
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hFFFF;
    check("x0_ready", 32'(bus.a_ready), 32'(1));
    cyc();
    bus.a_valid = 1'b0;
    check("x0_busy", 32'(bus.busy), 32'(0));
    check("x0_wr_en", 32'(bus.wr_en), 32'(0));
    cyc();
    check("x0_wr_en_late", 32'(bus.wr_en), 32'(0));
    check("x0_busy_late", 32'(bus.busy), 32'(0));

`ifdef WB_BYPASS_EN
    // Bypass from pending slot, then from the write register
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h33;
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd0;
    cyc();
    bus.a_valid = 1'b0;
    #1;
    check("byp_slot_hit", 32'(bus.byp1_hit), 32'(1));
    check("byp_slot_data", bus.byp1_data, 32'h33);
    check("byp_x0_hit", 32'(bus.byp2_hit), 32'(0));
    cyc();
    check("byp_wr_hit", 32'(bus.byp1_hit), 32'(1));
    check("byp_wr_data", bus.byp1_data, 32'h33);
    cyc();
    check("byp_idle_hit", 32'(bus.byp1_hit), 32'(0));
`endif

    // Reset mid-flight discards both pending writes
    bus.a_valid = 1'b1; bus.a_addr = 5'd9;  bus.a_data = 32'h99;
    bus.b_valid = 1'b1; bus.b_addr = 5'd10; bus.b_data = 32'hAA;
    cyc();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("mid_wr_en", 32'(bus.wr_en), 32'(0));
    check("mid_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("mid_wr_data", bus.wr_data, 32'h0);
    check("mid_busy_after", 32'(bus.busy), 32'(0));
    repeat (4) cyc();
    check("mid_rf_x9", rf[9], 32'h0);
    check("mid_rf_x10", rf[10], 32'h0);

    // Random traffic on a small register range to force same-register conflicts
    for (int k = 0; k < 1500; k++) begin
      if (!bus.a_valid || acc_a) begin
        bus.a_valid = ($urandom_range(0, 99) < 65);
        bus.a_addr  = AW'($urandom_range(0, 3));
        bus.a_data  = $urandom;
      end
      if (!bus.b_valid || acc_b) begin
        bus.b_valid = ($urandom_range(0, 99) < 65);
        bus.b_addr  = AW'($urandom_range(0, 3));
        bus.b_data  = $urandom;
      end
      rst = ($urandom_range(0, 499) == 0);
`ifdef WB_BYPASS_EN
      bus.rs1_addr = AW'($urandom_range(0, 3));
      bus.rs2_addr = AW'($urandom_range(0, 3));
`endif
      cyc();
`ifdef WB_BYPASS_EN
      check_byp();
`endif
    end
    rst = 1'b0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    repeat (4) cyc();
    check("drain_empty", 32'(oq.size()), 32'(0));
    for (int i = 0; i < 32; i++) begin
      check("final_rf", rf[i], exp_rf[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
